// File: rtl/cook_timer_ctrl.sv
// mm:ss BCD countdown controller: set/start/pause/clear, then a bounded alarm.
// Optional blink output enabled by defining COOK_TIMER_BLINK_EN.
module cook_timer_ctrl #(
  parameter int unsigned ALARM_SEC = 10
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       clk_sec,
  input  logic       btn_start,
  input  logic       btn_min_inc,
  input  logic       btn_sec_inc,
  input  logic       btn_clear,
  output logic [3:0] min10,
  output logic [3:0] min1,
  output logic [3:0] sec10,
  output logic [3:0] sec1,
  output logic       running,
  output logic       alarm
`ifdef COOK_TIMER_BLINK_EN
  ,
  output logic       blink
`endif
);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_PAUSE, ST_ALARM} state_t;

  localparam logic [7:0] ALARM_LIMIT = 8'(ALARM_SEC);

  state_t     state_q, state_d;
  logic [3:0] min10_q, min10_d, min1_q, min1_d;
  logic [3:0] sec10_q, sec10_d, sec1_q, sec1_d;
  logic [7:0] acnt_q, acnt_d;
  logic       running_q, running_d, alarm_q, alarm_d;
  logic       time_zero, time_one;

  assign time_zero = (min10_q == 4'd0) && (min1_q == 4'd0) &&
                     (sec10_q == 4'd0) && (sec1_q == 4'd0);
  assign time_one  = (min10_q == 4'd0) && (min1_q == 4'd0) &&
                     (sec10_q == 4'd0) && (sec1_q == 4'd1);

  always_comb begin
    state_d = state_q;
    min10_d = min10_q;
    min1_d  = min1_q;
    sec10_d = sec10_q;
    sec1_d  = sec1_q;
    acnt_d  = acnt_q;
    if (btn_clear) begin
      state_d = ST_IDLE;
      min10_d = 4'd0;
      min1_d  = 4'd0;
      sec10_d = 4'd0;
      sec1_d  = 4'd0;
      acnt_d  = 8'd0;
    end else if (btn_start) begin
      case (state_q)
        ST_IDLE:  if (!time_zero) state_d = ST_RUN;
        ST_RUN:   state_d = ST_PAUSE;
        ST_PAUSE: if (!time_zero) state_d = ST_RUN;
        default: begin
          state_d = ST_IDLE;
          acnt_d  = 8'd0;
        end
      endcase
    end else if (state_q == ST_IDLE || state_q == ST_PAUSE) begin
      if (btn_min_inc) begin
        if (min1_q == 4'd9) begin
          min1_d  = 4'd0;
          min10_d = (min10_q == 4'd9) ? 4'd0 : min10_q + 4'd1;
        end else begin
          min1_d = min1_q + 4'd1;
        end
      end
      // Seconds wrap 59 -> 00 on their own; minutes are not touched.
      if (btn_sec_inc) begin
        if (sec1_q == 4'd9) begin
          sec1_d  = 4'd0;
          sec10_d = (sec10_q == 4'd5) ? 4'd0 : sec10_q + 4'd1;
        end else begin
          sec1_d = sec1_q + 4'd1;
        end
      end
    end else if (state_q == ST_RUN && clk_sec) begin
      if (time_one) begin
        sec1_d  = 4'd0;
        state_d = ST_ALARM;
        acnt_d  = 8'd0;
      end else if (sec1_q != 4'd0) begin
        sec1_d = sec1_q - 4'd1;
      end else begin
        sec1_d = 4'd9;
        if (sec10_q != 4'd0) begin
          sec10_d = sec10_q - 4'd1;
        end else begin
          sec10_d = 4'd5;
          if (min1_q != 4'd0) begin
            min1_d = min1_q - 4'd1;
          end else begin
            min1_d  = 4'd9;
            min10_d = min10_q - 4'd1;
          end
        end
      end
    end else if (state_q == ST_ALARM && clk_sec) begin
      if (acnt_q + 8'd1 == ALARM_LIMIT) begin
        state_d = ST_IDLE;
        acnt_d  = 8'd0;
      end else begin
        acnt_d = acnt_q + 8'd1;
      end
    end
    running_d = (state_d == ST_RUN);
    alarm_d   = (state_d == ST_ALARM);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      min10_q   <= 4'd0;
      min1_q    <= 4'd0;
      sec10_q   <= 4'd0;
      sec1_q    <= 4'd0;
      acnt_q    <= 8'd0;
      running_q <= 1'b0;
      alarm_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      min10_q   <= min10_d;
      min1_q    <= min1_d;
      sec10_q   <= sec10_d;
      sec1_q    <= sec1_d;
      acnt_q    <= acnt_d;
      running_q <= running_d;
      alarm_q   <= alarm_d;
    end
  end

  assign min10   = min10_q;
  assign min1    = min1_q;
  assign sec10   = sec10_q;
  assign sec1    = sec1_q;
  assign running = running_q;
  assign alarm   = alarm_q;

`ifdef COOK_TIMER_BLINK_EN
  logic blink_q, blink_d;

  // Toggle only while staying in PAUSE/ALARM; any move to IDLE or RUN clears it.
  always_comb begin
    blink_d = blink_q;
    if (state_d == ST_IDLE || state_d == ST_RUN) begin
      blink_d = 1'b0;
    end else if (clk_sec && !btn_clear && !btn_start &&
                 (state_q == ST_PAUSE || state_q == ST_ALARM)) begin
      blink_d = ~blink_q;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) blink_q <= 1'b0;
    else          blink_q <= blink_d;
  end

  assign blink = blink_q;
`endif

endmodule

// File: tb/tb_cook_timer_ctrl.sv
// Scoreboard bench for cook_timer_ctrl: directed plan plus random stimulus vs. an arithmetic model.
module tb_cook_timer_ctrl;

  localparam int ALARM_SEC = 10;
  localparam int MS_IDLE = 0, MS_RUN = 1, MS_PAUSE = 2, MS_ALARM = 3;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic clk_sec = 1'b0, btn_start = 1'b0, btn_min_inc = 1'b0;
  logic btn_sec_inc = 1'b0, btn_clear = 1'b0;
  logic [3:0] min10, min1, sec10, sec1;
  logic running, alarm;
  logic blink_w;

  cook_timer_ctrl #(.ALARM_SEC(ALARM_SEC)) dut (
    .clk(clk), .reset_n(reset_n), .clk_sec(clk_sec), .btn_start(btn_start),
    .btn_min_inc(btn_min_inc), .btn_sec_inc(btn_sec_inc), .btn_clear(btn_clear),
    .min10(min10), .min1(min1), .sec10(sec10), .sec1(sec1),
    .running(running), .alarm(alarm)
`ifdef COOK_TIMER_BLINK_EN
    , .blink(blink_w)
`endif
  );
`ifndef COOK_TIMER_BLINK_EN
  assign blink_w = 1'b0;
`endif

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit verbose = 1'b1;

  // Reference model: plain minutes/seconds integers and a state code.
  int m_st = MS_IDLE, m_min = 0, m_sec = 0, m_acnt = 0;
  bit m_blink = 1'b0;

  typedef struct {
    logic [18:0] v;
    string       tag;
  } exp_t;
  exp_t exp_q[$];

  function automatic logic [18:0] model_vec();
    return {4'(m_min / 10), 4'(m_min % 10), 4'(m_sec / 10), 4'(m_sec % 10),
            m_st == MS_RUN, m_st == MS_ALARM, m_blink};
  endfunction

  function automatic logic [18:0] dut_vec();
    return {min10, min1, sec10, sec1, running, alarm, blink_w};
  endfunction

  task automatic model_step(input bit c, input bit s, input bit mi, input bit si, input bit p);
    int prev = m_st;
    int t;
    if (c) begin
      m_st = MS_IDLE; m_min = 0; m_sec = 0; m_acnt = 0;
    end else if (s) begin
      t = m_min * 60 + m_sec;
      if (m_st == MS_IDLE || m_st == MS_PAUSE) begin
        if (t != 0) m_st = MS_RUN;
      end else if (m_st == MS_RUN) m_st = MS_PAUSE;
      else begin
        m_st = MS_IDLE; m_acnt = 0;
      end
    end else if (m_st == MS_IDLE || m_st == MS_PAUSE) begin
      if (mi) m_min = (m_min + 1) % 100;
      if (si) m_sec = (m_sec + 1) % 60;
    end else if (m_st == MS_RUN && p) begin
      t = m_min * 60 + m_sec - 1;
      m_min = t / 60; m_sec = t % 60;
      if (t == 0) begin
        m_st = MS_ALARM; m_acnt = 0;
      end
    end else if (m_st == MS_ALARM && p) begin
      m_acnt++;
      if (m_acnt == ALARM_SEC) begin
        m_st = MS_IDLE; m_acnt = 0;
      end
    end
`ifdef COOK_TIMER_BLINK_EN
    if (m_st == MS_IDLE || m_st == MS_RUN) m_blink = 1'b0;
    else if (p && !c && !s && (prev == MS_PAUSE || prev == MS_ALARM)) m_blink = ~m_blink;
`else
    if (prev < 0) m_blink = 1'b0;
`endif
  endtask

  // Drive one cycle of inputs at the falling edge and queue the expected result.
  task automatic cyc(input bit c, input bit s, input bit mi, input bit si, input bit p,
                     input string tag = "rand");
    exp_t e;
    @(negedge clk);
    btn_clear = c; btn_start = s; btn_min_inc = mi; btn_sec_inc = si; clk_sec = p;
    model_step(c, s, mi, si, p);
    e.v = model_vec();
    e.tag = tag;
    exp_q.push_back(e);
  endtask

  task automatic idle_cycle(); cyc(0, 0, 0, 0, 0, "idle"); endtask

  task automatic async_reset();
    logic [18:0] got;
    @(posedge clk);
    #3;
    btn_clear = 0; btn_start = 0; btn_min_inc = 0; btn_sec_inc = 0; clk_sec = 0;
    reset_n = 1'b0;
    #1;
    got = dut_vec();
    checks++;
    if (got !== 19'd0) begin
      errors++;
      $display("FAIL async_reset got=%h required=%h", got, 19'd0);
    end else if (verbose) $display("txn async_reset ok outputs=%h", got);
    m_st = MS_IDLE; m_min = 0; m_sec = 0; m_acnt = 0; m_blink = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin : monitor
    exp_t e;
    logic [18:0] got;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        got = dut_vec();
        checks++;
        if (got !== e.v) begin
          errors++;
          $display("FAIL %s got=%02h%02h %1b%1b%1b required=%02h%02h %1b%1b%1b", e.tag,
                   got[18:11], got[10:3], got[2], got[1], got[0],
                   e.v[18:11], e.v[10:3], e.v[2], e.v[1], e.v[0]);
        end else if (verbose) begin
          $display("txn %s time=%h:%h run=%b alarm=%b blink=%b", e.tag,
                   got[18:11], got[10:3], got[2], got[1], got[0]);
        end
      end
    end
  end

  initial begin : stim
    int n;
    // Reset state, sampled while reset is held.
    #2;
    checks++;
    if (dut_vec() !== 19'd0) begin
      errors++;
      $display("FAIL reset_state got=%h required=%h", dut_vec(), 19'd0);
    end
    @(negedge clk);
    reset_n = 1'b1;

    // 2 min, 5 sec, start, 3 seconds -> 02:02 running.
    repeat (2) cyc(0, 0, 1, 0, 0, "min_inc");
    repeat (5) cyc(0, 0, 0, 1, 0, "sec_inc");
    cyc(0, 1, 0, 0, 0, "start");
    repeat (3) cyc(0, 0, 0, 0, 1, "tick");
    cyc(1, 0, 0, 0, 0, "clear");

    // 00:02 countdown into alarm, then alarm timeout.
    repeat (2) cyc(0, 0, 0, 1, 0, "sec_inc");
    cyc(0, 1, 0, 0, 0, "start");
    repeat (2) cyc(0, 0, 0, 0, 1, "tick_to_alarm");
    repeat (ALARM_SEC) cyc(0, 0, 0, 0, 1, "alarm_tick");
    idle_cycle();

    // 01:00 -> 00:59, pause on coincident tick, sec wrap without carry, start at zero.
    cyc(0, 0, 1, 0, 0, "min_inc");
    cyc(0, 1, 0, 0, 0, "start");
    cyc(0, 0, 0, 0, 1, "tick_borrow");
    cyc(0, 1, 0, 0, 1, "pause_with_tick");
    cyc(0, 0, 0, 0, 1, "pause_tick");
    cyc(0, 0, 0, 1, 0, "sec_wrap");
    cyc(0, 1, 0, 0, 0, "start_at_zero");
    cyc(0, 0, 1, 1, 0, "both_inc_pause");
    cyc(1, 0, 0, 0, 0, "clear");

    // 99:59 limits and wrap to 00:00, start ignored at zero.
    repeat (99) cyc(0, 0, 1, 0, 0, "min_inc");
    repeat (59) cyc(0, 0, 0, 1, 0, "sec_inc");
    cyc(0, 0, 1, 1, 0, "both_wrap");
    cyc(0, 1, 0, 0, 0, "start_zero_idle");

    // 05:30 running, clear beats start; then async reset mid-run.
    repeat (5) cyc(0, 0, 1, 0, 0, "min_inc");
    repeat (30) cyc(0, 0, 0, 1, 0, "sec_inc");
    cyc(0, 1, 0, 0, 0, "start");
    cyc(0, 0, 1, 1, 1, "inc_ignored_run");
    cyc(1, 1, 0, 0, 0, "clear_and_start");
    repeat (3) cyc(0, 0, 0, 1, 0, "sec_inc");
    cyc(0, 1, 0, 0, 0, "start");
    cyc(0, 0, 0, 0, 1, "tick");
    async_reset();

    // Pause blink sequence then resume (blink checked only when the port exists).
    repeat (3) cyc(0, 0, 1, 0, 0, "min_inc");
    cyc(0, 1, 0, 0, 0, "start");
    cyc(0, 1, 0, 0, 0, "pause");
    repeat (3) cyc(0, 0, 0, 0, 1, "blink_tick");
    cyc(0, 1, 0, 0, 0, "resume");
    cyc(1, 0, 0, 0, 0, "clear");

    // Random phase.
    verbose = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      n = $urandom_range(0, 999);
      cyc(n < 8,
          $urandom_range(0, 99) < 6,
          $urandom_range(0, 99) < 4,
          $urandom_range(0, 99) < 12,
          $urandom_range(0, 99) < 40,
          "rand");
      if (i == 1500) async_reset();
    end

    // Drain the scoreboard with a bounded wait.
    n = 0;
    while (exp_q.size() > 0 && n < 20) begin
      @(posedge clk);
      n++;
    end
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain got=%0d pending required=0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
